// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains the tx FIFO one byte per frame and
// shifts it out as start, 8 data LSB first, optional parity, stop.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNTW         = 10,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tx_en,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_out,
  output logic       o_fifo_rd,
  output logic       o_txd,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(CLKS_PER_BIT - 1);
  localparam logic HAS_PAR  = (PARITY != 0);
  localparam logic ODD_PAR  = (PARITY == 1);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic            r_stop;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_txd;
  logic            r_busy;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == LAST);
  assign o_fifo_rd = (r_state == S_FETCH) && !i_fifo_empty;
  assign o_txd     = r_txd;
  assign o_busy    = r_busy;

  // frame sequencer: state, bit timing, shift data and line level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (i_tx_en && !i_fifo_empty) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_shift <= i_fifo_out;
          r_par   <= ^i_fifo_out;
          r_cnt   <= '0;
          r_txd   <= 1'b0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              if (HAS_PAR) begin
                r_txd   <= r_par ^ ODD_PAR;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_stop  <= 1'b0;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
              r_txd <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_txd   <= 1'b1;
            r_stop  <= 1'b0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop == TWO_STOP) begin
              r_stop  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_stop <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
